// File: rtl/gapu_v2_core.sv
// Geometric-algebra product engine: loads multivectors A and B, accumulates C = A*B term by term, streams C out.
// Define GAPU_V2_METRIC_EN to add the metric_neg port (per-basis e_b^2 = -1 selection).
module gapu_v2_core #(
  parameter int N_BASIS = 5,
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_BASIS-1:0] out_addr,
  output logic [ACC_W-1:0]   out_data
`ifdef GAPU_V2_METRIC_EN
  ,
  input  logic [N_BASIS-1:0] metric_neg
`endif
);

  localparam int GA_DIM = 1 << N_BASIS;
  localparam logic [N_BASIS:0] LD_LAST = (N_BASIS+1)'(2*GA_DIM-1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, WRITE, DONE} state_t;

  state_t               state;
  logic [N_BASIS:0]     ld_cnt;
  logic [N_BASIS-1:0]   i_cnt;
  logic [N_BASIS-1:0]   j_cnt;
  logic                 dr_cnt;
  logic [N_BASIS-1:0]   wr_k;
  logic [N_BASIS-1:0]   wr_nxt;
  logic [N_BASIS-1:0]   metric_q;

  logic signed [DATA_W-1:0] a_rf  [GA_DIM];
  logic signed [DATA_W-1:0] b_rf  [GA_DIM];
  logic signed [ACC_W-1:0]  c_acc [GA_DIM];

  logic signed [ACC_W-1:0]  p_p1;
  logic [N_BASIS-1:0]       k_p1;
  logic                     vld_p1;

  assign wr_nxt = wr_k + 1'b1;

`ifndef GAPU_V2_METRIC_EN
  assign metric_q = '0;
`endif

  // Sign from reordering e_i*e_j into canonical blade order, plus negative-square contractions.
  function automatic logic reorder_sign(input logic [N_BASIS-1:0] ia,
                                        input logic [N_BASIS-1:0] jb,
                                        input logic [N_BASIS-1:0] mneg);
    logic               s;
    logic [N_BASIS-1:0] mask;
    s = ^(ia & jb & mneg);
    for (int b = 0; b < N_BASIS; b++) begin
      mask = N_BASIS'((1 << b) - 1);
      if (ia[b]) s = s ^ (^(jb & mask));
    end
    return s;
  endfunction

  function automatic logic signed [ACC_W-1:0] term_value(input logic signed [DATA_W-1:0] x,
                                                         input logic signed [DATA_W-1:0] y,
                                                         input logic                     neg);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    ext;
    prod = x * y;
    ext  = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
    return neg ? -ext : ext;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      ld_cnt    <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      dr_cnt    <= 1'b0;
      wr_k      <= '0;
`ifdef GAPU_V2_METRIC_EN
      metric_q  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            ld_cnt   <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            dr_cnt   <= 1'b0;
            wr_k     <= '0;
`ifdef GAPU_V2_METRIC_EN
            metric_q <= metric_neg;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LD_LAST) begin
              state    <= COMPUTE;
              in_ready <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          j_cnt <= j_cnt + 1'b1;
          if (j_cnt == '1) begin
            i_cnt <= i_cnt + 1'b1;
            if (i_cnt == '1) state <= DRAIN;
          end
        end
        DRAIN: begin
          dr_cnt <= ~dr_cnt;
          if (dr_cnt) begin
            state     <= WRITE;
            out_valid <= 1'b1;
            out_addr  <= '0;
            out_data  <= c_acc[0];
            wr_k      <= '0;
          end
        end
        WRITE: begin
          if (out_ready) begin
            if (wr_k == '1) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_addr  <= '0;
              out_data  <= '0;
              done      <= 1'b1;
            end else begin
              wr_k     <= wr_nxt;
              out_addr <= wr_nxt;
              out_data <= c_acc[wr_nxt];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      k_p1   <= '0;
      p_p1   <= '0;
      for (int n = 0; n < GA_DIM; n++) begin
        a_rf[n]  <= '0;
        b_rf[n]  <= '0;
        c_acc[n] <= '0;
      end
    end else begin
      if (state == LOAD && in_valid) begin
        if (!ld_cnt[N_BASIS]) a_rf[ld_cnt[N_BASIS-1:0]] <= $signed(in_data);
        else                  b_rf[ld_cnt[N_BASIS-1:0]] <= $signed(in_data);
      end
      // Stage 1: signed term and target blade
      vld_p1 <= (state == COMPUTE);
      k_p1   <= i_cnt ^ j_cnt;
      p_p1   <= term_value(a_rf[i_cnt], b_rf[j_cnt], reorder_sign(i_cnt, j_cnt, metric_q));
      // Stage 2: single-cycle read-modify-write, so repeated k needs no forwarding
      if (state == IDLE && start) begin
        for (int n = 0; n < GA_DIM; n++) c_acc[n] <= '0;
      end else if (vld_p1) begin
        c_acc[k_p1] <= c_acc[k_p1] + p_p1;
      end
    end
  end

endmodule
